// File: rtl/oumux_dat_route_pkg.sv
// Shared widths and helpers for the oumux output router.
package oumux_dat_route_pkg;

   localparam int unsigned DEF_DW    = 512;
   localparam int unsigned N_OUT     = 5;
   localparam int unsigned SEL_W     = 4;
   localparam int unsigned DEF_CNT_W = 16;

   // One-hot destination mask for a unicast index; out-of-range indices give an empty mask.
   function automatic logic [N_OUT-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
      logic [N_OUT-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         m[k] = (32'(idx) == k);
      end
      return m;
   endfunction

endpackage

// File: rtl/oumux_dat_route_if.sv
// Upstream beat handshake plus the fanned-out destination bus of the router.
interface oumux_dat_route_if
   import oumux_dat_route_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
) ();

   logic [DW-1:0]    t_oumux_dat;
   logic             t_oumux_valid;
   logic             t_oumux_ready;
   logic [SEL_W-1:0] t_c_dat;
   logic             t_c_bcast;
   logic [N_OUT-1:0] t_c_mask;
   logic [DW-1:0]    i_dat;
   logic [N_OUT-1:0] i_valid;
   logic [N_OUT-1:0] i_ready;

   // Upstream source and kernel-side consumers
   modport master (
      output t_oumux_dat, t_oumux_valid, t_c_dat, t_c_bcast, t_c_mask, i_ready,
      input  t_oumux_ready, i_dat, i_valid
   );

   // Router
   modport slave (
      input  t_oumux_dat, t_oumux_valid, t_c_dat, t_c_bcast, t_c_mask, i_ready,
      output t_oumux_ready, i_dat, i_valid
   );

endinterface

// File: rtl/oumux_dat_route_tgt_decode.sv
// Turns the per-beat routing controls into the destination mask.
module oumux_dat_route_tgt_decode
   import oumux_dat_route_pkg::*;
(
   input  logic [SEL_W-1:0] t_c_dat,
   input  logic             t_c_bcast,
   input  logic [N_OUT-1:0] t_c_mask,
   output logic [N_OUT-1:0] tgt_c
);

   // Broadcast takes the mask verbatim; unicast decodes the index (illegal index -> empty set)
   always_comb begin
      tgt_c = onehot_sel(t_c_dat);
      if (t_c_bcast) begin
         tgt_c = t_c_mask;
      end
   end

endmodule

// File: rtl/oumux_dat_route.sv
// Output router: holds one beat and presents it to a unicast or broadcast destination set.
// Destination count and select width come from the package; data and counter widths are parameters.
module oumux_dat_route
   import oumux_dat_route_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   oumux_dat_route_if.slave   bus,
   output logic [SEL_W-1:0]   sel,
   output logic               err_drop,
   output logic [CNT_W-1:0]   drop_cnt
);

   logic [N_OUT-1:0] pend_q, pend_d;
   logic [DW-1:0]    dat_q, dat_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N_OUT-1:0] tgt_c;
   logic [N_OUT-1:0] pend_ret_c;
   logic             ready_c;
   logic             accept_c;

   oumux_dat_route_tgt_decode u_tgt_decode (
      .t_c_dat   (bus.t_c_dat),
      .t_c_bcast (bus.t_c_bcast),
      .t_c_mask  (bus.t_c_mask),
      .tgt_c     (tgt_c)
   );

   // The slot is free when every still-owed destination accepts this cycle
   always_comb begin
      pend_ret_c = pend_q & ~bus.i_ready;
      ready_c    = (pend_ret_c == '0);
      accept_c   = bus.t_oumux_valid & ready_c;
   end

   // Next state: retire accepted destinations, load a new beat on accept, count empty-target drops
   always_comb begin
      pend_d = pend_ret_c;
      dat_d  = dat_q;
      sel_d  = sel_q;
      err_d  = 1'b0;
      cnt_d  = cnt_q;
      if (accept_c) begin
         pend_d = tgt_c;
         dat_d  = bus.t_oumux_dat;
         sel_d  = bus.t_c_dat;
         if (tgt_c == '0) begin
            err_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State registers; reset discards any held beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         dat_q  <= '0;
         sel_q  <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         dat_q  <= dat_d;
         sel_q  <= sel_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.t_oumux_ready = ready_c;
   assign bus.i_valid       = pend_q;
   assign bus.i_dat         = dat_q;
   assign sel               = sel_q;
   assign err_drop          = err_q;
   assign drop_cnt          = cnt_q;

endmodule

// File: tb/tb_oumux_dat_route.sv
// Scoreboard bench for oumux_dat_route: per-destination expected-beat queues fed on every
// upstream handshake, drained and compared whenever a destination handshake occurs.
module tb_oumux_dat_route;
   import oumux_dat_route_pkg::*;

   localparam int unsigned DW      = DEF_DW;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic [DW-1:0]    d;
      logic [SEL_W-1:0] s;
   } exp_t;

   logic             clk;
   logic             reset_n;
   logic [SEL_W-1:0] sel;
   logic             err_drop;
   logic [CNT_W-1:0] drop_cnt;

   oumux_dat_route_if #(.DW(DW)) bus ();

   oumux_dat_route #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .sel      (sel),
      .err_drop (err_drop),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_deliv = 0;

   exp_t q[N_OUT][$];
   int   exp_cnt = 0;
   logic exp_err = 1'b0;

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [DW-1:0] rand_dat();
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Reference target set from the routing rules
   function automatic logic [N_OUT-1:0] model_tgt(input logic bc, input logic [SEL_W-1:0] s,
                                                  input logic [N_OUT-1:0] m);
      if (bc) return m;
      if (int'(s) < int'(N_OUT)) return N_OUT'(1) << s;
      return '0;
   endfunction

   // Monitor/scoreboard: sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      logic [N_OUT-1:0] v_exp;
      logic             all_clear;
      logic [N_OUT-1:0] tgt;
      exp_t             e;
      if (!reset_n) begin
         for (int k = 0; k < int'(N_OUT); k++) q[k].delete();
         exp_cnt = 0;
         exp_err = 1'b0;
      end else begin
         for (int k = 0; k < int'(N_OUT); k++) v_exp[k] = (q[k].size() != 0);
         chk("i_valid", DW'(bus.i_valid), DW'(v_exp));
         chk("err_drop", DW'(err_drop), DW'(exp_err));
         chk("drop_cnt", DW'(drop_cnt), DW'(exp_cnt));
         all_clear = 1'b1;
         for (int k = 0; k < int'(N_OUT); k++)
            if (q[k].size() != 0 && !bus.i_ready[k]) all_clear = 1'b0;
         chk("t_oumux_ready", DW'(bus.t_oumux_ready), DW'(all_clear));
         for (int k = 0; k < int'(N_OUT); k++) begin
            if (bus.i_valid[k] && bus.i_ready[k]) begin
               if (q[k].size() == 0) begin
                  chk("unexpected_delivery", DW'(k), DW'(N_OUT));
               end else begin
                  e = q[k].pop_front();
                  n_deliv++;
                  chk("i_dat", bus.i_dat, e.d);
                  chk("sel", DW'(sel), DW'(e.s));
               end
            end
         end
         exp_err = 1'b0;
         if (bus.t_oumux_valid && bus.t_oumux_ready) begin
            tgt = model_tgt(bus.t_c_bcast, bus.t_c_dat, bus.t_c_mask);
            e.d = bus.t_oumux_dat;
            e.s = bus.t_c_dat;
            for (int k = 0; k < int'(N_OUT); k++) if (tgt[k]) q[k].push_back(e);
            if (tgt == '0) begin
               exp_err = 1'b1;
               if (exp_cnt < CNT_MAX) exp_cnt++;
            end
         end
      end
   end

   // Applies one cycle of stimulus just after the edge, returns at the following falling edge
   task automatic drive(input logic v, input logic bc, input logic [SEL_W-1:0] s,
                        input logic [N_OUT-1:0] m, input logic [DW-1:0] d, input logic [N_OUT-1:0] r);
      @(posedge clk);
      #1;
      bus.t_oumux_valid = v;
      bus.t_c_bcast     = bc;
      bus.t_c_dat       = s;
      bus.t_c_mask      = m;
      bus.t_oumux_dat   = d;
      bus.i_ready       = r;
      @(negedge clk);
   endtask

   task automatic idle(input logic [N_OUT-1:0] r);
      drive(1'b0, 1'b0, '0, '0, '0, r);
   endtask

   logic [DW-1:0] a;
   int            d0;
   int            left;

   initial begin
      reset_n           = 1'b0;
      bus.t_oumux_valid = 1'b0;
      bus.t_c_bcast     = 1'b0;
      bus.t_c_dat       = '0;
      bus.t_c_mask      = '0;
      bus.t_oumux_dat   = '0;
      bus.i_ready       = '0;
      repeat (2) @(negedge clk);
      chk("rst_i_valid", DW'(bus.i_valid), '0);
      chk("rst_i_dat", bus.i_dat, '0);
      chk("rst_sel", DW'(sel), '0);
      chk("rst_drop_cnt", DW'(drop_cnt), '0);
      chk("rst_ready", DW'(bus.t_oumux_ready), DW'(1));
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Unicast to destination 2 with all consumers ready
      a = rand_dat();
      drive(1'b1, 1'b0, 4'd2, '0, a, 5'b11111);
      chk("t1_ready", DW'(bus.t_oumux_ready), DW'(1));
      idle(5'b11111);
      chk("t1_i_valid", DW'(bus.i_valid), DW'(5'b00100));
      chk("t1_i_dat", bus.i_dat, a);
      idle(5'b11111);
      chk("t1_i_valid_gone", DW'(bus.i_valid), '0);

      // Broadcast 10011 with staggered acceptance
      drive(1'b1, 1'b1, 4'd0, 5'b10011, rand_dat(), 5'b00000);
      idle(5'b00001);
      chk("t2_pend0", DW'(bus.i_valid), DW'(5'b10011));
      chk("t2_ready0", DW'(bus.t_oumux_ready), '0);
      idle(5'b10010);
      chk("t2_pend1", DW'(bus.i_valid), DW'(5'b10010));
      chk("t2_ready1", DW'(bus.t_oumux_ready), DW'(1));
      idle(5'b00000);
      chk("t2_pend2", DW'(bus.i_valid), '0);

      // Empty broadcast mask is a drop
      drive(1'b1, 1'b1, 4'd0, 5'b00000, rand_dat(), 5'b11111);
      idle(5'b11111);
      chk("t5_err", DW'(err_drop), DW'(1));
      chk("t5_cnt", DW'(drop_cnt), DW'(1));
      chk("t5_i_valid", DW'(bus.i_valid), '0);

      // Illegal unicast index, then enough repeats to saturate the counter
      drive(1'b1, 1'b0, 4'd7, '0, rand_dat(), 5'b11111);
      idle(5'b11111);
      chk("t3_err", DW'(err_drop), DW'(1));
      chk("t3_cnt", DW'(drop_cnt), DW'(2));
      chk("t3_i_valid", DW'(bus.i_valid), '0);
      idle(5'b11111);
      chk("t3_err_pulse", DW'(err_drop), '0);
      for (int i = 0; i < CNT_MAX + 3; i++) drive(1'b1, 1'b0, 4'd7, '0, rand_dat(), 5'b11111);
      idle(5'b11111);
      chk("t3_cnt_sat", DW'(drop_cnt), DW'(CNT_MAX));

      // Back-to-back unicast stream to rotating destinations
      d0 = n_deliv;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, SEL_W'(i % int'(N_OUT)), '0, rand_dat(), 5'b11111);
         chk("t4_ready", DW'(bus.t_oumux_ready), DW'(1));
      end
      idle(5'b11111);
      idle(5'b11111);
      chk("t4_delivered", DW'(n_deliv - d0), DW'(8));

      // Reset while a broadcast is still owed
      drive(1'b1, 1'b1, 4'd0, 5'b01100, rand_dat(), 5'b00000);
      idle(5'b00000);
      chk("t6_pend", DW'(bus.i_valid), DW'(5'b01100));
      @(posedge clk);
      #1 reset_n = 1'b0;
      bus.t_oumux_valid = 1'b0;
      #1;
      chk("t6_i_valid", DW'(bus.i_valid), '0);
      chk("t6_cnt", DW'(drop_cnt), '0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(5'b00000);
      chk("t6_ready", DW'(bus.t_oumux_ready), DW'(1));

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               SEL_W'($urandom_range(0, 7)), N_OUT'($urandom), rand_dat(),
               N_OUT'($urandom | $urandom));
      end
      repeat (3) idle(5'b11111);
      left = 0;
      for (int k = 0; k < int'(N_OUT); k++) left += q[k].size();
      chk("drain_empty", DW'(left), '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
